// File: rtl/flag_ctx_regs.sv
// Flag register with masked overwrite/sticky writes, clear, and a small LIFO
// stack that saves and restores the whole flag word.
module flag_ctx_regs #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             en,
    input  logic             sticky,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] q_r;
    logic [CW-1:0]    count_r;
    logic             ovf_r;
    logic             unf_r;
    logic [WIDTH-1:0] stack_r [DEPTH];

    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic [CW-1:0]    count_m1_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic [WIDTH-1:0] q_next_s;
    logic [CW-1:0]    count_next_s;

    assign full_s     = (count_r == CW'(DEPTH));
    assign empty_s    = (count_r == CW'(0));
    // Simultaneous push and pop cancel out and touch neither stack nor error flags.
    assign push_ok_s  = push & ~pop & ~full_s;
    assign pop_ok_s   = pop & ~push & ~empty_s;
    assign ovf_set_s  = push & ~pop & full_s;
    assign unf_set_s  = pop & ~push & empty_s;
    assign count_m1_s = count_r - CW'(1);
    assign wr_idx_s   = count_r[AW-1:0];
    assign rd_idx_s   = count_m1_s[AW-1:0];

    // Next flag value: clr beats a restore, a restore beats a write.
    always_comb begin
        q_next_s = q_r;
        if (clr) begin
            q_next_s = '0;
        end else if (pop_ok_s) begin
            q_next_s = stack_r[rd_idx_s];
        end else if (en) begin
            if (sticky) begin
                q_next_s = q_r | (d & wr_mask);
            end else begin
                q_next_s = (q_r & ~wr_mask) | (d & wr_mask);
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Next stack occupancy.
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_ok_s) begin
            count_next_s = count_m1_s;
        end else begin
            count_next_s = count_r;
        end
    end

    // Flag, occupancy and error-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r     <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            q_r     <= q_next_s;
            count_r <= count_next_s;
            ovf_r   <= ovf_r | ovf_set_s;
            unf_r   <= unf_r | unf_set_s;
        end
    end

    // Stack storage; entries above count are never read, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) begin
            stack_r[wr_idx_s] <= q_r;
        end
    end

    assign q     = q_r;
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign ovf   = ovf_r;
    assign unf   = unf_r;

endmodule

// File: tb/tb_flag_ctx_regs.sv
// Directed bench for flag_ctx_regs at WIDTH=4, DEPTH=2.
module tb_flag_ctx_regs;

    logic       clk;
    logic       reset;
    logic [3:0] d;
    logic [3:0] wr_mask;
    logic       en;
    logic       sticky;
    logic       clr;
    logic       push;
    logic       pop;
    logic [3:0] q;
    logic [1:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;

    int compared;
    int mismatched;

    flag_ctx_regs #(.WIDTH(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .d(d), .wr_mask(wr_mask), .en(en),
        .sticky(sticky), .clr(clr), .push(push), .pop(pop), .q(q),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        reset = 1'b0; d = 4'b0000; wr_mask = 4'b0000; en = 1'b0;
        sticky = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    // One clock: inputs were applied #1 after the previous edge; sample #1 after this one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; step(); idle();
    endtask

    task automatic write(input logic [3:0] val, input logic [3:0] msk, input logic stk);
        idle(); en = 1'b1; d = val; wr_mask = msk; sticky = stk; step(); idle();
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (q !== 4'b0000 || count !== 2'd0 || ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            $display("FAIL reset: q=%b count=%0d ovf=%b unf=%b empty=%b full=%b, required 0000 0 0 0 1 0",
                     q, count, ovf, unf, empty, full);
            mismatched++;
        end
    endtask

    task automatic test_overwrite();
        do_reset();
        write(4'b1010, 4'b1111, 1'b0);
        compared++;
        if (q !== 4'b1010) begin
            $display("FAIL overwrite_full: q=%b required 1010", q); mismatched++;
        end
        write(4'b0101, 4'b0011, 1'b0);
        compared++;
        if (q !== 4'b1001) begin
            $display("FAIL overwrite_mask: q=%b required 1001", q); mismatched++;
        end
        idle(); d = 4'b1111; wr_mask = 4'b1111; step();
        compared++;
        if (q !== 4'b1001) begin
            $display("FAIL hold_en0: q=%b required 1001", q); mismatched++;
        end
    endtask

    task automatic test_sticky();
        do_reset();
        write(4'b0001, 4'b1111, 1'b0);
        write(4'b0100, 4'b1111, 1'b1);
        compared++;
        if (q !== 4'b0101) begin
            $display("FAIL sticky_or: q=%b required 0101", q); mismatched++;
        end
        write(4'b0000, 4'b1111, 1'b1);
        compared++;
        if (q !== 4'b0101) begin
            $display("FAIL sticky_zero: q=%b required 0101", q); mismatched++;
        end
        write(4'b1010, 4'b0010, 1'b1);
        compared++;
        if (q !== 4'b0111) begin
            $display("FAIL sticky_mask: q=%b required 0111", q); mismatched++;
        end
    endtask

    task automatic test_stack();
        do_reset();
        write(4'b0011, 4'b1111, 1'b0);
        idle(); push = 1'b1; step(); idle();
        write(4'b1100, 4'b1111, 1'b0);
        idle(); push = 1'b1; step(); idle();
        compared++;
        if (count !== 2'd2 || full !== 1'b1 || ovf !== 1'b0) begin
            $display("FAIL push_full: count=%0d full=%b ovf=%b required 2 1 0", count, full, ovf); mismatched++;
        end
        idle(); push = 1'b1; step(); idle();
        compared++;
        if (count !== 2'd2 || ovf !== 1'b1 || q !== 4'b1100) begin
            $display("FAIL push_ovf: count=%0d ovf=%b q=%b required 2 1 1100", count, ovf, q); mismatched++;
        end
        // Restore must take priority over a same-cycle write.
        idle(); pop = 1'b1; en = 1'b1; d = 4'b0110; wr_mask = 4'b1111; step(); idle();
        compared++;
        if (q !== 4'b1100 || count !== 2'd1) begin
            $display("FAIL pop1: q=%b count=%0d required 1100 1", q, count); mismatched++;
        end
        idle(); pop = 1'b1; step(); idle();
        compared++;
        if (q !== 4'b0011 || count !== 2'd0 || empty !== 1'b1) begin
            $display("FAIL pop2: q=%b count=%0d empty=%b required 0011 0 1", q, count, empty); mismatched++;
        end
    endtask

    task automatic test_underflow();
        // Continues from test_stack: empty, ovf already set.
        idle(); pop = 1'b1; en = 1'b1; d = 4'b0110; wr_mask = 4'b1111; step(); idle();
        compared++;
        if (unf !== 1'b1 || q !== 4'b0110 || count !== 2'd0) begin
            $display("FAIL pop_unf: unf=%b q=%b count=%0d required 1 0110 0", unf, q, count); mismatched++;
        end
        idle(); step(); step(); write(4'b0001, 4'b1111, 1'b0);
        compared++;
        if (ovf !== 1'b1 || unf !== 1'b1) begin
            $display("FAIL err_sticky: ovf=%b unf=%b required 1 1", ovf, unf); mismatched++;
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        write(4'b0010, 4'b1111, 1'b0);
        idle(); push = 1'b1; step(); idle();
        idle(); push = 1'b1; pop = 1'b1; en = 1'b1; d = 4'b1111; wr_mask = 4'b1111; step(); idle();
        compared++;
        if (count !== 2'd1 || q !== 4'b1111 || ovf !== 1'b0 || unf !== 1'b0) begin
            $display("FAIL push_pop: count=%0d q=%b ovf=%b unf=%b required 1 1111 0 0", count, q, ovf, unf); mismatched++;
        end
        idle(); clr = 1'b1; push = 1'b1; step(); idle();
        compared++;
        if (q !== 4'b0000 || count !== 2'd2) begin
            $display("FAIL clr_push: q=%b count=%0d required 0000 2", q, count); mismatched++;
        end
        // Top entry holds 1111 (pre-clear value); clr overrides the restore.
        idle(); clr = 1'b1; pop = 1'b1; step(); idle();
        compared++;
        if (q !== 4'b0000 || count !== 2'd1) begin
            $display("FAIL clr_pop: q=%b count=%0d required 0000 1", q, count); mismatched++;
        end
        idle(); pop = 1'b1; step(); idle();
        compared++;
        if (q !== 4'b0010 || count !== 2'd0) begin
            $display("FAIL pop_after_clr: q=%b count=%0d required 0010 0", q, count); mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write(4'b0101, 4'b1111, 1'b0);
        idle(); push = 1'b1; en = 1'b1; d = 4'b1111; wr_mask = 4'b1111; step(); idle();
        compared++;
        if (q !== 4'b1111 || count !== 2'd1) begin
            $display("FAIL push_write: q=%b count=%0d required 1111 1", q, count); mismatched++;
        end
        idle(); push = 1'b1; step(); idle();
        idle(); push = 1'b1; step(); idle();
        compared++;
        if (count !== 2'd2 || ovf !== 1'b1) begin
            $display("FAIL fill_ovf: count=%0d ovf=%b required 2 1", count, ovf); mismatched++;
        end
        idle(); pop = 1'b1; step(); pop = 1'b1; step(); idle();
        compared++;
        if (q !== 4'b0101 || count !== 2'd0) begin
            $display("FAIL b2b_pop: q=%b count=%0d required 0101 0", q, count); mismatched++;
        end
        idle(); push = 1'b1; step(); push = 1'b1; step(); push = 1'b1; step(); idle();
        idle(); reset = 1'b1; push = 1'b1; en = 1'b1; d = 4'b1111; wr_mask = 4'b1111; step(); idle();
        compared++;
        if (q !== 4'b0000 || count !== 2'd0 || ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1) begin
            $display("FAIL reset_mid: q=%b count=%0d ovf=%b unf=%b empty=%b required 0000 0 0 0 1",
                     q, count, ovf, unf, empty);
            mismatched++;
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        idle();
        reset = 1'b1;
        step(); step();
        test_reset();
        test_overwrite();
        test_sticky();
        test_stack();
        test_underflow();
        test_push_pop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
